// File: rtl/seg7_scan_disp.sv
// Multiplexed hex 7-segment driver with debounced keys, edit cursor on DP,
// leading-zero blanking, display enable and a frame-synchronous load buffer.
module seg7_scan_disp #(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 20000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            key,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [DIGITS-1:0]     select,
    output logic [6:0]            segment7x,
    output logic                  dp
);

    localparam int IDXW = $clog2(DIGITS);
    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int DEBW = $clog2(DEB_CYCLES);
    localparam logic [IDXW-1:0]   LAST_IDX  = IDXW'(DIGITS - 1);
    localparam logic [DIVW-1:0]   LAST_DIV  = DIVW'(SCAN_DIV - 1);
    localparam logic [DEBW-1:0]   LAST_DEB  = DEBW'(DEB_CYCLES - 1);
    localparam logic [DIGITS-1:0] SEL_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    logic [3:0]             r_keyMeta;
    logic [3:0]             r_keySync;
    logic [3:0]             r_keyState;
    logic [3:0]             r_keyPulse;
    logic [3:0][DEBW-1:0]   r_debCnt;

    logic [DIVW-1:0]        r_div;
    logic [IDXW-1:0]        r_idx;
    logic                   w_tick;
    logic                   w_frameEnd;

    logic [DIGITS-1:0][3:0] r_disp;
    logic [DIGITS-1:0][3:0] r_buf;
    logic                   r_bufFull;
    logic [IDXW-1:0]        r_cursor;
    logic                   r_blankEn;
    logic                   r_dispEn;

    logic [DIGITS-1:0]      w_zeroFrom;
    logic [DIGITS-1:0]      w_sel;
    logic                   w_blank;
    logic [6:0]             w_glyph;

    function automatic logic [6:0] hexGlyph(input logic [3:0] n);
        case (n)
            4'h0: hexGlyph = 7'b1000000;
            4'h1: hexGlyph = 7'b1111001;
            4'h2: hexGlyph = 7'b0100100;
            4'h3: hexGlyph = 7'b0110000;
            4'h4: hexGlyph = 7'b0011001;
            4'h5: hexGlyph = 7'b0010010;
            4'h6: hexGlyph = 7'b0000010;
            4'h7: hexGlyph = 7'b1111000;
            4'h8: hexGlyph = 7'b0000000;
            4'h9: hexGlyph = 7'b0010000;
            4'hA: hexGlyph = 7'b0001000;
            4'hB: hexGlyph = 7'b0000011;
            4'hC: hexGlyph = 7'b1000110;
            4'hD: hexGlyph = 7'b0100001;
            4'hE: hexGlyph = 7'b0000110;
            default: hexGlyph = 7'b0001110;
        endcase
    endfunction

    // Debounce tracks the accepted level; a pulse fires only on an accepted press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_keyMeta  <= '1;
            r_keySync  <= '1;
            r_keyState <= '1;
            r_keyPulse <= '0;
            r_debCnt   <= '0;
        end else begin
            r_keyMeta <= key;
            r_keySync <= r_keyMeta;
            for (int k = 0; k < 4; k++) begin
                r_keyPulse[k] <= 1'b0;
                if (r_keySync[k] == r_keyState[k]) begin
                    r_debCnt[k] <= '0;
                end else if (r_debCnt[k] == LAST_DEB) begin
                    r_debCnt[k]   <= '0;
                    r_keyState[k] <= r_keySync[k];
                    r_keyPulse[k] <= ~r_keySync[k];
                end else begin
                    r_debCnt[k] <= r_debCnt[k] + 1'b1;
                end
            end
        end
    end

    assign w_tick     = (r_div == LAST_DIV);
    assign w_frameEnd = w_tick && (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // A frame-boundary copy takes priority over a same-cycle digit edit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp    <= '0;
            r_buf     <= '0;
            r_bufFull <= 1'b0;
            r_cursor  <= '0;
            r_blankEn <= 1'b0;
            r_dispEn  <= 1'b1;
        end else begin
            if (data_valid && !r_bufFull) begin
                r_buf     <= data_in;
                r_bufFull <= 1'b1;
            end
            if (w_frameEnd && r_bufFull) begin
                r_disp    <= r_buf;
                r_bufFull <= 1'b0;
            end else if (r_keyPulse[1]) begin
                r_disp[r_cursor] <= r_disp[r_cursor] + 4'd1;
            end
            if (r_keyPulse[0]) begin
                r_cursor <= (r_cursor == LAST_IDX) ? '0 : r_cursor + 1'b1;
            end
            if (r_keyPulse[2]) begin
                r_blankEn <= ~r_blankEn;
            end
            if (r_keyPulse[3]) begin
                r_dispEn <= ~r_dispEn;
            end
        end
    end

    assign data_ready = ~r_bufFull;

    always_comb begin : zeroScan
        logic run;
        run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run           = run & (r_disp[i] == 4'd0);
            w_zeroFrom[i] = run;
        end
    end

    always_comb begin
        w_sel        = '1;
        w_sel[r_idx] = 1'b0;
        w_blank      = r_blankEn && (r_idx != '0) && w_zeroFrom[r_idx];
        w_glyph      = w_blank ? 7'h7F : hexGlyph(r_disp[r_idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            select    <= SEL_RESET;
            segment7x <= 7'b1000000;
            dp        <= 1'b0;
        end else if (!r_dispEn) begin
            select    <= '1;
            segment7x <= 7'h7F;
            dp        <= 1'b1;
        end else begin
            select    <= w_sel;
            segment7x <= w_glyph;
            dp        <= (r_idx == r_cursor) ? 1'b0 : 1'b1;
        end
    end

endmodule
